memory_loader: RTL and testbench
================================

MEMORY_LOADER -- requirements
Module: memory_loader

Interface
REQ-001 Parameter WIDTH, default 128, number of words per memory load (memory depth).
REQ-002 Parameter LOG_WIDTH, default 7, width of address/counters; SHALL satisfy 2**LOG_WIDTH >= WIDTH.
REQ-003 Parameter WORD, default 16, bits per loaded word.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-007 abort  input  1  cancel current operation; returns to IDLE.
REQ-008 s_valid  input  1  upstream word valid.
REQ-009 s_data  input  WORD  upstream word.
REQ-010 s_ready  output  1  block accepts a word this cycle.
REQ-011 mem_we  output  1  write strobe to downstream memory.
REQ-012 mem_en  output  1  read/drain strobe to downstream memory.
REQ-013 mem_data  output  WORD  word written to memory, valid when mem_we=1.
REQ-014 wr_cnt  output  LOG_WIDTH  words accepted in current load.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a load and drain complete.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, DRAIN, DONE; state registered.
REQ-018 IDLE: s_ready=0; start=1 -> LOAD next cycle, wr_cnt and rd_cnt cleared to 0.
REQ-019 LOAD: s_ready=1 combinationally from state; transfer occurs when s_valid and s_ready both high at a rising edge.
REQ-020 Each transfer SHALL drive mem_we=1 and mem_data=s_data on the following cycle (latency 1); no transfer -> mem_we=0, mem_data holds last value.
REQ-021 wr_cnt SHALL increment by 1 per transfer; on the transfer taking wr_cnt from WIDTH-1 to WIDTH, state -> DRAIN and s_ready drops the next cycle; wr_cnt saturates at WIDTH (counter width LOG_WIDTH+1 internally; output truncated to LOG_WIDTH, so reads 0 after a full load at default WIDTH).
REQ-022 DRAIN SHALL begin only after the final mem_we cycle; mem_en asserted for exactly WIDTH consecutive cycles, counted by rd_cnt, then state -> DONE.
REQ-023 mem_we and mem_en SHALL never be high in the same cycle.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 start outside IDLE SHALL be ignored; start and abort together in IDLE -> remain IDLE.
REQ-026 abort in any state SHALL force IDLE next cycle; mem_we, mem_en, s_ready, busy low from that cycle; a write pending from the abort cycle's transfer SHALL be discarded; done not pulsed.
REQ-027 s_valid while s_ready=0 SHALL have no effect; s_data not sampled.

Reset
REQ-028 rst=1 at a rising edge SHALL set state IDLE, wr_cnt=0, rd_cnt=0, mem_data=0, mem_we=0, mem_en=0, s_ready=0, busy=0, done=0; rst dominates abort and start.
REQ-029 Reset mid-LOAD or mid-DRAIN SHALL discard progress; next load starts at address 0.

Configuration
REQ-030 Macro MEMORY_LOADER_CHECKSUM_EN defined: extra output checksum [WORD-1:0] = modulo-2**WORD sum of all words accepted in current load, cleared on start acceptance and reset, held stable from DONE until next start.
REQ-031 Macro undefined: checksum port and accumulator SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset, start, 128 back-to-back words 0..127 -> 128 mem_we cycles, mem_data 0..127 each one cycle after acceptance, then 128 mem_en cycles, done pulse, busy low.
REQ-033 s_valid toggling 1/0 every cycle during LOAD -> exactly 128 writes, no duplicates or gaps in mem_data sequence, s_ready low immediately after 128th acceptance.
REQ-034 abort after 50 transfers -> IDLE next cycle, no further mem_we, no done; subsequent start reloads from wr_cnt=0.
REQ-035 rst asserted on 10th DRAIN cycle -> mem_en low next cycle, all outputs at reset values, no done.
REQ-036 start during DRAIN and while busy -> ignored, single done pulse only.
REQ-037 With MEMORY_LOADER_CHECKSUM_EN, 128 words of 16'h0200 -> checksum 16'h0000 (wrap); words 1..128 -> 16'h2040.

Source files
------------

// File: rtl/memory_loader.sv
// memory_loader: accepts WIDTH streamed words, writes them to a downstream memory, then drains it.
// Optional running checksum output is enabled by defining MEMORY_LOADER_CHECKSUM_EN.
module memory_loader #(
    parameter int WIDTH     = 128,
    parameter int LOG_WIDTH = 7,
    parameter int WORD      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 s_valid,
    input  logic [WORD-1:0]      s_data,
    output logic                 s_ready,
    output logic                 mem_we,
    output logic                 mem_en,
    output logic [WORD-1:0]      mem_data,
    output logic [LOG_WIDTH-1:0] wr_cnt,
    output logic                 busy,
    output logic                 done
`ifdef MEMORY_LOADER_CHECKSUM_EN
    ,
    output logic [WORD-1:0]      checksum
`endif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int WCW = LOG_WIDTH + 1;
    localparam logic [LOG_WIDTH:0]   LAST_WR = WCW'(WIDTH - 1);
    localparam logic [LOG_WIDTH-1:0] LAST_RD = LOG_WIDTH'(WIDTH - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [LOG_WIDTH:0]   r_wr_cnt;
    logic [LOG_WIDTH-1:0] r_rd_cnt;
    logic                 r_mem_we;
    logic [WORD-1:0]      r_mem_data;
    logic                 w_xfer;
    logic                 w_start_ok;
    logic                 w_rd_step;

    assign s_ready    = (r_state == S_LOAD);
    // An abort in the same cycle as a handshake discards that word entirely.
    assign w_xfer     = s_ready && s_valid && !abort;
    assign w_start_ok = (r_state == S_IDLE) && start && !abort;
    // The first DRAIN cycle still carries the final write, so reads wait it out.
    assign w_rd_step  = (r_state == S_DRAIN) && !r_mem_we;

    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next_state = S_LOAD;
                S_LOAD:  if (w_xfer && r_wr_cnt == LAST_WR) w_next_state = S_DRAIN;
                S_DRAIN: if (w_rd_step && r_rd_cnt == LAST_RD) w_next_state = S_DONE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_mem_we   <= 1'b0;
            r_mem_data <= '0;
        end else begin
            r_state  <= w_next_state;
            r_mem_we <= w_xfer;
            if (w_start_ok) begin
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end else begin
                if (w_xfer)    r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_rd_step) r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_xfer) r_mem_data <= s_data;
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_en   = w_rd_step;
    assign mem_data = r_mem_data;
    assign wr_cnt   = r_wr_cnt[LOG_WIDTH-1:0];
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

`ifdef MEMORY_LOADER_CHECKSUM_EN
    logic [WORD-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + s_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_memory_loader.sv
// Scoreboard bench for memory_loader: stimulus pushes expected writes, a negedge monitor pops them.
// Checksum scenarios run only when MEMORY_LOADER_CHECKSUM_EN is defined.
module tb_memory_loader;
    localparam int WIDTH     = 128;
    localparam int LOG_WIDTH = 7;
    localparam int WORD      = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic                 s_valid;
    logic [WORD-1:0]      s_data;
    logic                 s_ready;
    logic                 mem_we;
    logic                 mem_en;
    logic [WORD-1:0]      mem_data;
    logic [LOG_WIDTH-1:0] wr_cnt;
    logic                 busy;
    logic                 done;
`ifdef MEMORY_LOADER_CHECKSUM_EN
    logic [WORD-1:0]      checksum;
`endif

    always #5 clk = ~clk;

    memory_loader #(.WIDTH(WIDTH), .LOG_WIDTH(LOG_WIDTH), .WORD(WORD)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .mem_we   (mem_we),
        .mem_en   (mem_en),
        .mem_data (mem_data),
        .wr_cnt   (wr_cnt),
        .busy     (busy),
        .done     (done)
`ifdef MEMORY_LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    logic [WORD-1:0] exp_q[$];
    logic [WORD-1:0] model_sum;
    logic [WORD-1:0] last_d;

    int cyc = 0;
    int en_count, done_count, we_count, first_en, last_en, last_we, done_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every write must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (mem_we) begin
            last_we = cyc;
            we_count++;
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("mem_data", mem_data, exp_q.pop_front());
        end
        if (mem_en) begin
            if (en_count == 0) first_en = cyc;
            last_en = cyc;
            en_count++;
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (mem_we || mem_en) check("we_en_exclusive", mem_we & mem_en, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        en_count = 0; done_count = 0; we_count = 0;
        first_en = -1; last_en = -1; last_we = -1; done_cyc = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr_cnt"}, wr_cnt, 0);
        check({tag, "_mem_data"}, mem_data, 0);
    endtask

    task automatic do_start();
        clear_stats();
        model_sum = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_wr_cnt", wr_cnt, 0);
`ifdef MEMORY_LOADER_CHECKSUM_EN
        check("start_checksum", checksum, 0);
`endif
    endtask

    // mode 0: counting data back-to-back, 1: valid toggles, 2: random valid,
    // 3: constant 16'h0200, other: data 1..N back-to-back
    task automatic load_words(input int mode, input int n_words);
        int acc;
        int k;
        logic v;
        logic [WORD-1:0] d;
        acc = 0;
        k = 0;
        while (acc < n_words && k < 16 * WIDTH) begin
            case (mode)
                0:       begin v = 1'b1; d = WORD'(acc); end
                1:       begin v = (k % 2 == 0); d = WORD'($urandom); end
                2:       begin v = ($urandom_range(0, 3) != 0); d = WORD'($urandom); end
                3:       begin v = 1'b1; d = 16'h0200; end
                default: begin v = 1'b1; d = WORD'(acc + 1); end
            endcase
            check("s_ready_load", s_ready, 1);
            check("wr_cnt_load", wr_cnt, acc[LOG_WIDTH-1:0]);
            s_valid = v;
            s_data  = d;
            if (v) begin
                exp_q.push_back(d);
                model_sum = model_sum + d;
                last_d = d;
                acc++;
            end
            tick();
            k++;
        end
        s_valid = 1'b0;
        s_data  = WORD'($urandom);
        check("load_budget", acc, n_words);
        if (n_words == WIDTH) begin
            check("s_ready_after_last", s_ready, 0);
            check("wr_cnt_full_trunc", wr_cnt, WIDTH % (1 << LOG_WIDTH));
        end
    endtask

    task automatic wait_done(input bit poke_start);
        int budget;
        int steps;
        budget = 4 * WIDTH;
        steps = 0;
        while (!done && budget > 0) begin
            if (steps == 2) check("mem_data_hold", mem_data, last_d);
            if (poke_start && (steps == 3 || steps == 20)) start = 1'b1;
            tick();
            start = 1'b0;
            steps++;
            budget--;
        end
        check("done_seen", done, 1);
        tick();
        check("done_count", done_count, 1);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("queue_drained", exp_q.size(), 0);
        check("write_count", we_count, WIDTH);
        check("read_count", en_count, WIDTH);
        check("drain_after_last_we", first_en, last_we + 1);
        check("drain_contiguous", last_en - first_en, WIDTH - 1);
        check("done_after_drain", done_cyc, last_en + 1);
`ifdef MEMORY_LOADER_CHECKSUM_EN
        check("checksum_done", checksum, model_sum);
`endif
    endtask

    initial begin
        int nen;
        int budget;
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        clear_stats();
        model_sum = '0;
        last_d = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // back-to-back counting load
        do_start();
        load_words(0, WIDTH);
        wait_done(1'b0);

        // start with abort in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);
        check("start_abort_idle_ready", s_ready, 0);

        // toggling valid, with starts poked during drain
        do_start();
        load_words(1, WIDTH);
        wait_done(1'b1);

        // abort after 50 transfers; abort-cycle handshake is discarded
        do_start();
        load_words(2, 50);
        abort = 1'b1; s_valid = 1'b1; s_data = WORD'($urandom);
        tick();
        abort = 1'b0; s_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", s_ready, 0);
        check("abort_mem_we", mem_we, 0);
        repeat (5) tick();
        check("abort_no_done", done_count, 0);
        check("abort_writes", we_count, 50);
        check("abort_queue", exp_q.size(), 0);
        do_start();
        load_words(2, WIDTH);
        wait_done(1'b0);

        // reset mid-load, then reload from zero
        do_start();
        load_words(2, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_load");
        check("rst_load_queue", exp_q.size(), 0);
        do_start();
        load_words(2, WIDTH);
        wait_done(1'b0);

        // reset on the 10th drain cycle
        do_start();
        load_words(2, WIDTH);
        nen = 0;
        budget = 4 * WIDTH;
        while (budget > 0) begin
            if (mem_en) nen++;
            if (nen == 10) break;
            tick();
            budget--;
        end
        check("drain_reached_10", nen, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("rst_drain");
        repeat (4) tick();
        check("rst_drain_no_done", done_count, 0);
        check("rst_drain_reads", en_count, 10);

`ifdef MEMORY_LOADER_CHECKSUM_EN
        do_start();
        load_words(3, WIDTH);
        wait_done(1'b0);
        check("checksum_wrap", checksum, 16'h0000);
        do_start();
        load_words(4, WIDTH);
        wait_done(1'b0);
        repeat (3) tick();
        check("checksum_1_to_128", checksum, 16'h2040);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
